ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
// - Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs (*_e).
// - Applies operand forwarding, runs the ALU, and resolves branch/jump (PCSrc, PC target).
// - Captures the results into the EX/MEM pipeline register (*_m), which has stall and flush control.
// PARAMETERS
// - DATA_WIDTH  32  datapath width
// - ADDR_WIDTH  5   register-file address width
// PORTS
// - i_clk          in   1           clock; all state updates on posedge
// - i_rst_n        in   1           asynchronous reset, active-low
// - i_regwrite_e   in   1           register-file write enable from ID/EX
// - i_resultsrc_e  in   2           writeback select from ID/EX
// - i_memwrite_e   in   1           store enable from ID/EX
// - i_jump_e       in   1           jump instruction in EX
// - i_branch_e     in   1           beq instruction in EX
// - i_aluctrl_e    in   3           ALU operation select
// - i_alusrc_e     in   1           1: ALU B operand = immext, 0: B operand = forwarded rs2
// - i_rs1_data_e   in   DATA_WIDTH  rs1 value read in ID
// - i_rs2_data_e   in   DATA_WIDTH  rs2 value read in ID
// - i_pc_e         in   DATA_WIDTH  PC of the instruction in EX
// - i_rd_addr_e    in   ADDR_WIDTH  destination register
// - i_immext_e     in   DATA_WIDTH  sign-extended immediate
// - i_pc4_e        in   DATA_WIDTH  PC+4 of the instruction in EX
// - i_fwd_a_e      in   2           forwarding select for operand A (from hazard unit)
// - i_fwd_b_e      in   2           forwarding select for operand B (from hazard unit)
// - i_result_w     in   DATA_WIDTH  writeback-stage result
// - i_stall_m      in   1           hold the EX/MEM register
// - i_flush_m      in   1           insert a bubble into EX/MEM
// - o_pcsrc_e      out  1           redirect fetch (combinational)
// - o_pctarget_e   out  DATA_WIDTH  branch/jump target = i_pc_e + i_immext_e (combinational)
// - o_regwrite_m   out  1           registered control to MEM
// - o_resultsrc_m  out  2           registered control to MEM
// - o_memwrite_m   out  1           registered control to MEM
// - o_aluresult_m  out  DATA_WIDTH  registered ALU result; also the forward source for EX
// - o_writedata_m  out  DATA_WIDTH  registered forwarded rs2 (store data)
// - o_rd_addr_m    out  ADDR_WIDTH  registered destination register
// - o_pc4_m        out  DATA_WIDTH  registered PC+4
// BEHAVIOUR
// - Reset: every *_m output is 0 while i_rst_n=0, and is cleared immediately when reset asserts, including mid-stall.
// - Forwarding mux, fwd_a/fwd_b encoding:
//   - 00: i_rsX_data_e
//   - 01: i_result_w
//   - 10: o_aluresult_m
//   - 11: reserved, treated as 00
// - srcA = fwdA. srcB = i_alusrc_e ? i_immext_e : fwdB.
// - ALU, all arithmetic modulo 2^DATA_WIDTH, no overflow flag:
//   - 000 add
//   - 001 sub
//   - 010 and
//   - 011 or
//   - 100 xor
//   - 101 slt (signed; result is 1 or 0, zero-extended)
//   - 110 sll by srcB[4:0]
//   - 111 srl by srcB[4:0]
// - zero = (alu result == 0).
// - o_pcsrc_e = (i_branch_e & zero) | i_jump_e. This is same-cycle, with no register in the path.
// - EX/MEM register update on each posedge, in priority order:
//   1. i_flush_m=1: regwrite/memwrite/resultsrc/rd_addr become 0, and data fields become 0. Flush beats stall.
//   2. i_stall_m=1: all *_m fields hold their current value.
//   3. Otherwise: capture the EX values. Latency is 1 cycle from *_e to *_m.
// - o_writedata_m is fwdB, independent of i_alusrc_e.
// - The write to x0 is not filtered here. The regfile ignores rd=0.
// CONFIGURATION
// - Macro EX_FWD_EN:
//   - Defined: forwarding muxes are present as described above.
//   - Undefined: fwdA = i_rs1_data_e and fwdB = i_rs2_data_e. i_fwd_a_e, i_fwd_b_e and i_result_w are ignored, and the hazard unit must stall on RAW instead.
// TESTING
// 1. Reset: assert i_rst_n=0 mid-stream with i_stall_m=1 -> all *_m read 0 with no clock edge; after release, the next edge captures.
// 2. ALU: add 7+5 -> 12; sub 5-7 -> 0xFFFFFFFE; slt -1 vs 1 -> 1; sll 1 by 31 -> 0x80000000; srl with B=0x21 shifts by 1.
// 3. Branch: beq with rs1=rs2=9, pc=0x100, imm=0x10 -> same cycle o_pcsrc_e=1 and o_pctarget_e=0x110; rs2=8 -> o_pcsrc_e=0. jump=1 -> o_pcsrc_e=1 regardless of operands.
// 4. Forwarding (EX_FWD_EN): rs1_data=1, aluresult_m=40, fwd_a=10, add imm 2 -> 42; fwd_a=01, result_w=3 -> 5; fwd_a=11 -> 3.
// 5. Stall/flush: hold 4 cycles with stall -> *_m unchanged; stall+flush in the same cycle -> regwrite_m=0, memwrite_m=0, rd_addr_m=0.
// 6. Store: memwrite, alusrc=1, fwd_b=10, aluresult_m=0xAB -> writedata_m=0xAB and aluresult_m = rs1 + imm after 1 cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage
// ----------------------------------------------------------------------------
// Execute stage of a 5-stage RV32I pipeline plus the EX/MEM pipeline register.
// It selects the operands (optionally forwarded), runs the ALU, resolves
// beq/jump in the same cycle, and registers the results for the MEM stage.
//
// Configuration macro: EX_FWD_EN
//   defined   : operand forwarding muxes from WB (i_result_w) and MEM
//               (o_aluresult_m) are present, selected by i_fwd_a_e/i_fwd_b_e.
//   undefined : operands come straight from the ID/EX register. The forwarding
//               inputs are ignored, so the hazard unit must stall on RAW.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_*_e                     ID/EX register outputs (control, operands, PC)
//   i_fwd_a_e, i_fwd_b_e      forwarding selects from the hazard unit
//   i_result_w                writeback-stage result (forward source)
//   i_stall_m, i_flush_m      EX/MEM hold / bubble insert (flush wins)
//   o_pcsrc_e, o_pctarget_e   combinational fetch redirect and target
//   o_*_m                     EX/MEM register outputs to the MEM stage
// ============================================================================
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_regwrite_e,
    input  logic [1:0]            i_resultsrc_e,
    input  logic                  i_memwrite_e,
    input  logic                  i_jump_e,
    input  logic                  i_branch_e,
    input  logic [2:0]            i_aluctrl_e,
    input  logic                  i_alusrc_e,
    input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
    input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
    input  logic [DATA_WIDTH-1:0] i_pc_e,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
    input  logic [DATA_WIDTH-1:0] i_immext_e,
    input  logic [DATA_WIDTH-1:0] i_pc4_e,
    input  logic [1:0]            i_fwd_a_e,
    input  logic [1:0]            i_fwd_b_e,
    input  logic [DATA_WIDTH-1:0] i_result_w,
    input  logic                  i_stall_m,
    input  logic                  i_flush_m,
    output logic                  o_pcsrc_e,
    output logic [DATA_WIDTH-1:0] o_pctarget_e,
    output logic                  o_regwrite_m,
    output logic [1:0]            o_resultsrc_m,
    output logic                  o_memwrite_m,
    output logic [DATA_WIDTH-1:0] o_aluresult_m,
    output logic [DATA_WIDTH-1:0] o_writedata_m,
    output logic [ADDR_WIDTH-1:0] o_rd_addr_m,
    output logic [DATA_WIDTH-1:0] o_pc4_m
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    alu_op_e               alu_op;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  zero;

    assign alu_op = alu_op_e'(i_aluctrl_e);

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
`ifdef EX_FWD_EN
    // 2'b11 is reserved and falls back to the register-file value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        fwd_a = i_rs1_data_e;
        fwd_b = i_rs2_data_e;
        case (i_fwd_a_e)
            2'b01:   fwd_a = i_result_w;
            2'b10:   fwd_a = o_aluresult_m;
            default: fwd_a = i_rs1_data_e;
        endcase
        case (i_fwd_b_e)
            2'b01:   fwd_b = i_result_w;
            2'b10:   fwd_b = o_aluresult_m;
            default: fwd_b = i_rs2_data_e;
        endcase
    end
`else
    assign fwd_a = i_rs1_data_e;
    assign fwd_b = i_rs2_data_e;

    // Forwarding inputs are deliberately dead in this build.
    logic unused_fwd;
    assign unused_fwd = ^{i_fwd_a_e, i_fwd_b_e, i_result_w};
`endif

    assign src_a = fwd_a;
    assign src_b = i_alusrc_e ? i_immext_e : fwd_b;

    // ------------------------------------------------------------------
    // ALU (modulo 2^DATA_WIDTH, shifts use only src_b[4:0])
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}},
                                   ($signed(src_a) < $signed(src_b))};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            ALU_SRL: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Same-cycle redirect: no register between the ALU and fetch.
    assign o_pcsrc_e    = (i_branch_e & zero) | i_jump_e;
    assign o_pctarget_e = i_pc_e + i_immext_e;

    // ------------------------------------------------------------------
    // EX/MEM pipeline register: reset > flush > stall > capture.
    // Store data is the forwarded rs2, never the immediate.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs as they were before the edge.
            o_regwrite_m  <= 1'b0;
            o_resultsrc_m <= 2'b00;
            o_memwrite_m  <= 1'b0;
            o_aluresult_m <= '0;
            o_writedata_m <= '0;
            o_rd_addr_m   <= '0;
            o_pc4_m       <= '0;
        end else if (i_flush_m) begin
            o_regwrite_m  <= 1'b0;
            o_resultsrc_m <= 2'b00;
            o_memwrite_m  <= 1'b0;
            o_aluresult_m <= '0;
            o_writedata_m <= '0;
            o_rd_addr_m   <= '0;
            o_pc4_m       <= '0;
        end else if (!i_stall_m) begin
            o_regwrite_m  <= i_regwrite_e;
            o_resultsrc_m <= i_resultsrc_e;
            o_memwrite_m  <= i_memwrite_e;
            o_aluresult_m <= alu_result;
            o_writedata_m <= fwd_b;
            o_rd_addr_m   <= i_rd_addr_e;
            o_pc4_m       <= i_pc4_e;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// tb_ex_mem_stage
// ----------------------------------------------------------------------------
// Directed bench for ex_mem_stage. Inputs change on the falling edge; the
// combinational redirect is sampled 1 time unit later, registered outputs
// 1 time unit after the rising edge. Forwarding expectations follow
// EX_FWD_EN the same way the design does.
// ============================================================================
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
    logic [1:0]    resultsrc_e, fwd_a_e, fwd_b_e;
    logic [2:0]    aluctrl_e;
    logic [DW-1:0] rs1_e, rs2_e, pc_e, imm_e, pc4_e, result_w;
    logic [AW-1:0] rd_e;
    logic          stall_m, flush_m;
    logic          pcsrc_e;
    logic [DW-1:0] pctarget_e;
    logic          regwrite_m, memwrite_m;
    logic [1:0]    resultsrc_m;
    logic [DW-1:0] aluresult_m, writedata_m, pc4_m;
    logic [AW-1:0] rd_m;

    // Whole EX/MEM register as one vector:
    // {regwrite, resultsrc, memwrite, rd, aluresult, writedata, pc4}
    logic [1+2+1+AW+3*DW-1:0] m_bus;
    assign m_bus = {regwrite_m, resultsrc_m, memwrite_m, rd_m,
                    aluresult_m, writedata_m, pc4_m};

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_mem_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_regwrite_e  (regwrite_e),
        .i_resultsrc_e (resultsrc_e),
        .i_memwrite_e  (memwrite_e),
        .i_jump_e      (jump_e),
        .i_branch_e    (branch_e),
        .i_aluctrl_e   (aluctrl_e),
        .i_alusrc_e    (alusrc_e),
        .i_rs1_data_e  (rs1_e),
        .i_rs2_data_e  (rs2_e),
        .i_pc_e        (pc_e),
        .i_rd_addr_e   (rd_e),
        .i_immext_e    (imm_e),
        .i_pc4_e       (pc4_e),
        .i_fwd_a_e     (fwd_a_e),
        .i_fwd_b_e     (fwd_b_e),
        .i_result_w    (result_w),
        .i_stall_m     (stall_m),
        .i_flush_m     (flush_m),
        .o_pcsrc_e     (pcsrc_e),
        .o_pctarget_e  (pctarget_e),
        .o_regwrite_m  (regwrite_m),
        .o_resultsrc_m (resultsrc_m),
        .o_memwrite_m  (memwrite_m),
        .o_aluresult_m (aluresult_m),
        .o_writedata_m (writedata_m),
        .o_rd_addr_m   (rd_m),
        .o_pc4_m       (pc4_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an ALU-type instruction (no branch/jump, no forwarding change).
    task automatic drive_alu(input logic [2:0] ctrl, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic src,
                             input logic [DW-1:0] imm);
        aluctrl_e = ctrl;
        rs1_e     = a;
        rs2_e     = b;
        alusrc_e  = src;
        imm_e     = imm;
        branch_e  = 1'b0;
        jump_e    = 1'b0;
    endtask

    task automatic drive_ctrl(input logic rw, input logic [1:0] rs,
                              input logic mw, input logic [AW-1:0] rd,
                              input logic [DW-1:0] pc4);
        regwrite_e  = rw;
        resultsrc_e = rs;
        memwrite_e  = mw;
        rd_e        = rd;
        pc4_e       = pc4;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [1+2+1+AW+3*DW-1:0] exp_bus;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (m_bus !== '0)
            $display("FAIL reset_initial: m_bus=%h required 0", m_bus);
        else pass_cnt++;

        // Load something non-zero.
        @(negedge clk);
        rst_n = 1'b1;
        drive_ctrl(1'b1, 2'b01, 1'b0, 5'd5, 32'h14);
        drive_alu(3'b000, 32'd7, 32'd5, 1'b0, 32'd0);
        @(posedge clk); #1;
        exp_bus = {1'b1, 2'b01, 1'b0, 5'd5, 32'd12, 32'd5, 32'h14};
        total_cnt++;
        if (m_bus !== exp_bus)
            $display("FAIL reset_first_capture: m_bus=%h required %h", m_bus, exp_bus);
        else pass_cnt++;

        // Reset mid-stall clears without any clock edge.
        @(negedge clk);
        stall_m = 1'b1;
        rst_n   = 1'b0;
        #1;
        total_cnt++;
        if (m_bus !== '0)
            $display("FAIL reset_async_in_stall: m_bus=%h required 0", m_bus);
        else pass_cnt++;

        // Release: the next edge captures the EX values.
        @(negedge clk);
        rst_n   = 1'b1;
        stall_m = 1'b0;
        drive_ctrl(1'b1, 2'b00, 1'b0, 5'd9, 32'h18);
        @(posedge clk); #1;
        exp_bus = {1'b1, 2'b00, 1'b0, 5'd9, 32'd12, 32'd5, 32'h18};
        total_cnt++;
        if (m_bus !== exp_bus)
            $display("FAIL reset_release_capture: m_bus=%h required %h", m_bus, exp_bus);
        else pass_cnt++;
    endtask

    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]    ctrl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          src;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v[10];
        v[0] = '{3'b000, 32'd7,        32'd5,          1'b0, 32'd0,     32'd12};
        v[1] = '{3'b001, 32'd5,        32'd7,          1'b0, 32'd0,     32'hFFFF_FFFE};
        v[2] = '{3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 32'd0,     32'h0000_00F0};
        v[3] = '{3'b011, 32'h0000_F000, 32'h0000_000F, 1'b0, 32'd0,     32'h0000_F00F};
        v[4] = '{3'b100, 32'h0000_00FF, 32'h0000_000F, 1'b0, 32'd0,     32'h0000_00F0};
        v[5] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,     32'd1};
        v[6] = '{3'b101, 32'd1,         32'hFFFF_FFFF, 1'b0, 32'd0,     32'd0};
        v[7] = '{3'b110, 32'd1,         32'd0,         1'b1, 32'd31,    32'h8000_0000};
        v[8] = '{3'b111, 32'h8000_0000, 32'd0,         1'b1, 32'h21,    32'h4000_0000};
        v[9] = '{3'b110, 32'd1,         32'h20,        1'b0, 32'd0,     32'd1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_alu(v[i].ctrl, v[i].a, v[i].b, v[i].src, v[i].imm);
            @(posedge clk); #1;
            total_cnt++;
            if (aluresult_m !== v[i].exp)
                $display("FAIL alu_vec%0d op=%0d: aluresult_m=%h required %h",
                         i, v[i].ctrl, aluresult_m, v[i].exp);
            else pass_cnt++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_branch();
        @(negedge clk);
        drive_alu(3'b001, 32'd9, 32'd9, 1'b0, 32'h10);
        pc_e     = 32'h100;
        branch_e = 1'b1;
        #1;
        total_cnt++;
        if ({pcsrc_e, pctarget_e} !== {1'b1, 32'h110})
            $display("FAIL beq_taken: pcsrc=%b target=%h required 1/00000110",
                     pcsrc_e, pctarget_e);
        else pass_cnt++;

        rs2_e = 32'd8;
        #1;
        total_cnt++;
        if (pcsrc_e !== 1'b0)
            $display("FAIL beq_not_taken: pcsrc=%b required 0", pcsrc_e);
        else pass_cnt++;

        // Zero ALU result without branch must not redirect.
        rs2_e    = 32'd9;
        branch_e = 1'b0;
        #1;
        total_cnt++;
        if (pcsrc_e !== 1'b0)
            $display("FAIL zero_no_branch: pcsrc=%b required 0", pcsrc_e);
        else pass_cnt++;

        // Jump redirects regardless of operands; target wraps modulo 2^32.
        rs2_e  = 32'd8;
        jump_e = 1'b1;
        pc_e   = 32'h200;
        imm_e  = 32'hFFFF_FFF0;
        #1;
        total_cnt++;
        if ({pcsrc_e, pctarget_e} !== {1'b1, 32'h1F0})
            $display("FAIL jump: pcsrc=%b target=%h required 1/000001f0",
                     pcsrc_e, pctarget_e);
        else pass_cnt++;
        @(negedge clk);
        jump_e = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Preload o_aluresult_m with 40, then exercise each fwd_a encoding.
    task automatic test_forwarding();
        logic [DW-1:0] exp10, exp01, exp11;
`ifdef EX_FWD_EN
        exp10 = 32'd42; exp01 = 32'd5; exp11 = 32'd3;
`else
        exp10 = 32'd3;  exp01 = 32'd3; exp11 = 32'd3;
`endif
        @(negedge clk);
        drive_alu(3'b000, 32'd40, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_alu(3'b000, 32'd1, 32'd0, 1'b1, 32'd2);
        fwd_a_e = 2'b10;
        @(posedge clk); #1;
        total_cnt++;
        if (aluresult_m !== exp10)
            $display("FAIL fwd_a_mem: aluresult_m=%0d required %0d", aluresult_m, exp10);
        else pass_cnt++;

        @(negedge clk);
        fwd_a_e  = 2'b01;
        result_w = 32'd3;
        @(posedge clk); #1;
        total_cnt++;
        if (aluresult_m !== exp01)
            $display("FAIL fwd_a_wb: aluresult_m=%0d required %0d", aluresult_m, exp01);
        else pass_cnt++;

        @(negedge clk);
        fwd_a_e = 2'b11;
        @(posedge clk); #1;
        total_cnt++;
        if (aluresult_m !== exp11)
            $display("FAIL fwd_a_reserved: aluresult_m=%0d required %0d", aluresult_m, exp11);
        else pass_cnt++;
        @(negedge clk);
        fwd_a_e = 2'b00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall_flush();
        logic [1+2+1+AW+3*DW-1:0] held;
        @(negedge clk);
        drive_ctrl(1'b1, 2'b10, 1'b1, 5'd7, 32'h24);
        drive_alu(3'b010, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 32'd0);
        @(posedge clk); #1;
        held = {1'b1, 2'b10, 1'b1, 5'd7, 32'h0000_00F0, 32'h0000_00FF, 32'h24};
        total_cnt++;
        if (m_bus !== held)
            $display("FAIL stall_preload: m_bus=%h required %h", m_bus, held);
        else pass_cnt++;

        @(negedge clk);
        stall_m = 1'b1;
        drive_ctrl(1'b0, 2'b01, 1'b0, 5'd3, 32'h88);
        drive_alu(3'b000, 32'd100, 32'd23, 1'b0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (m_bus !== held)
                $display("FAIL stall_hold_c%0d: m_bus=%h required %h", c, m_bus, held);
            else pass_cnt++;
        end

        // Flush beats stall: everything becomes a bubble.
        @(negedge clk);
        flush_m = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({regwrite_m, memwrite_m, rd_m} !== '0)
            $display("FAIL flush_over_stall_ctrl: rw=%b mw=%b rd=%0d required 0/0/0",
                     regwrite_m, memwrite_m, rd_m);
        else pass_cnt++;
        total_cnt++;
        if (m_bus !== '0)
            $display("FAIL flush_over_stall_all: m_bus=%h required 0", m_bus);
        else pass_cnt++;

        // Back to normal flow.
        @(negedge clk);
        flush_m = 1'b0;
        stall_m = 1'b0;
        @(posedge clk); #1;
        held = {1'b0, 2'b01, 1'b0, 5'd3, 32'd123, 32'd23, 32'h88};
        total_cnt++;
        if (m_bus !== held)
            $display("FAIL after_flush_capture: m_bus=%h required %h", m_bus, held);
        else pass_cnt++;
    endtask

    // ------------------------------------------------------------------
    // Store: address = rs1 + imm, data = forwarded rs2 even with alusrc=1.
    task automatic test_store();
        logic [DW-1:0] exp_wd;
`ifdef EX_FWD_EN
        exp_wd = 32'hAB;
`else
        exp_wd = 32'h55;
`endif
        @(negedge clk);
        drive_ctrl(1'b1, 2'b00, 1'b0, 5'd1, 32'h0);
        drive_alu(3'b000, 32'hAB, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_ctrl(1'b0, 2'b00, 1'b1, 5'd0, 32'h2C);
        drive_alu(3'b000, 32'h1000, 32'h55, 1'b1, 32'h8);
        fwd_b_e = 2'b10;
        @(posedge clk); #1;
        total_cnt++;
        if ({memwrite_m, regwrite_m, aluresult_m, writedata_m} !==
            {1'b1, 1'b0, 32'h1008, exp_wd})
            $display("FAIL store: mw=%b rw=%b addr=%h data=%h required 1/0/00001008/%h",
                     memwrite_m, regwrite_m, aluresult_m, writedata_m, exp_wd);
        else pass_cnt++;
        @(negedge clk);
        fwd_b_e = 2'b00;
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        stall_m  = 1'b0;
        flush_m  = 1'b0;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        result_w = '0;
        pc_e     = '0;
        drive_ctrl(1'b0, 2'b00, 1'b0, '0, '0);
        drive_alu(3'b000, '0, '0, 1'b0, '0);

        test_reset();
        test_alu();
        test_branch();
        test_forwarding();
        test_stall_flush();
        test_store();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
